mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of mips_cpu_bus between two internal requesters: instruction fetch (I) and load/store data (D).
- Serialises the requests, drives address/read/write/writedata/byteenable, honours waitrequest, and returns readdata plus a one-cycle done pulse to the winning requester.
- Sits between the CPU core datapath and the top-level bus ports.

Parameters:
- DATA_PRIORITY, 1, 1 = D always wins a simultaneous request; 0 = round-robin on ties.
- TIMEOUT_CYCLES, 255, waitrequest cycles tolerated before abort; used only with the optional feature. Width 8 bits, range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_done
- i_addr  in  32  fetch byte address
- i_done  out  1  one-cycle pulse: fetch complete
- i_rdata  out  32  fetched word; valid from i_done, held until next I completion
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store/load byte enables
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load word; valid from d_done, held until next D completion
- address  out  32  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  bus write data
- byteenable  out  4  bus byte enables
- waitrequest  in  1  slave stall
- readdata  in  32  bus read data; valid when read=1 and waitrequest=0
- busy  out  1  high in XFER and DONE
- err  out  1  one-cycle pulse on timeout abort; tied 0 when the feature is compiled out

Behaviour:
- Reset (synchronous, active-high, from any state):
  - State goes to IDLE; last_grant = I.
  - All outputs go to 0, including i_rdata and d_rdata.
  - Reset during XFER drops the bus strobes on the next edge; that transaction is lost and no done is issued.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE: if i_req or d_req is high, at the clock edge:
  - Pick a winner. Only one requesting: that one wins. Both requesting: D wins if DATA_PRIORITY=1; otherwise the requester not equal to last_grant wins.
  - Latch winner and last_grant.
  - Latch the bus address as {addr[31:2],2'b00}; address bits [1:0] are always forced to 0.
  - I winner: read=1, write=0, byteenable=4'b1111, writedata=0.
  - D winner: read=~d_we, write=d_we, byteenable=d_be, writedata=d_wdata.
  - Enter XFER. Strobes are asserted on the cycle after the request is seen.
- XFER:
  - Bus outputs are held stable while waitrequest=1.
  - At the first edge with waitrequest=0: capture readdata into the winner's rdata register (reads only; a write leaves d_rdata unchanged), deassert read/write, then enter DONE.
- DONE:
  - Winner's done = 1 for exactly this cycle; the other done stays 0.
  - No arbitration happens in DONE, so a requester's stale req is never re-granted.
  - Next state is IDLE.
- Latency:
  - Minimum 3 cycles from req seen in IDLE to done (zero-wait slave).
  - Each waitrequest cycle adds one cycle.
  - Back-to-back transactions from one requester take at least 3 cycles each.
- Protocol and boundary rules:
  - The losing requester keeps req high and is served next; no request is dropped.
  - With DATA_PRIORITY=1, I may starve under continuous D traffic. This is accepted: the core stalls fetch during a memory access.
  - If a requester drops req mid-transaction, the transaction still completes and done still pulses.
  - read and write are never both 1. Strobes are 0 in IDLE and DONE.
  - byteenable=0 with d_we=1 is passed through unchanged.

Optional Feature:
- Macro: MIPS_BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to XFER and increments each XFER cycle with waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES, on that edge: drop the strobes, leave rdata unchanged, pulse err and the winner's done together in DONE, then return to IDLE.
- Undefined: no counter, err tied 0, and XFER waits on waitrequest indefinitely.

Test Plan:
- Fetch with zero wait: i_req=1, i_addr=0xBFC00000, waitrequest=0, readdata=0x8C620000 -> read=1, address=0xBFC00000, byteenable=0xF in cycle 1; i_done in cycle 2 with i_rdata=0x8C620000; busy low in cycle 3.
- Load with 2 wait states: d_req=1, d_we=0, d_addr=0x00000007, waitrequest high for 2 cycles, readdata=9 -> address=0x00000004 throughout; d_done in cycle 4 with d_rdata=9; i_done stays 0.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3 -> write=1, writedata=0xDEADBEEF, byteenable=0x3; read=0; d_done pulses once; d_rdata unchanged.
- Simultaneous requests, DATA_PRIORITY=0, last_grant=I, both held high -> D served first, then I, then D; done pulses alternate and none is lost.
- Reset mid-XFER with waitrequest=1 -> strobes, busy and both done signals are 0 on the next edge; a new request after reset completes normally.
- With MIPS_BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest stuck high -> strobes drop after 4 stall cycles; err and d_done pulse together once.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) for the single Avalon-style CPU memory bus.
// Optional stalled-slave abort is compiled in with MIPS_BUS_ARB_TIMEOUT_EN.
module mips_bus_arbiter #(
  parameter int          DATA_PRIORITY  = 1,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t state, state_nxt;
  logic   win_d;    // current winner: 1 = D, 0 = I
  logic   last_d;   // last grant: 1 = D, 0 = I
  logic   grant_d;
  logic   abort;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = d_req && (!i_req || (DATA_PRIORITY != 0) || !last_d);
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = XFER;
      XFER:    if (!waitrequest || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_d      <= 1'b0;
      last_d     <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            win_d  <= grant_d;
            last_d <= grant_d;
            if (grant_d) begin
              address    <= {d_addr[31:2], 2'b00};
              read       <= ~d_we;
              write      <= d_we;
              byteenable <= d_be;
              writedata  <= d_wdata;
            end else begin
              address    <= {i_addr[31:2], 2'b00};
              read       <= 1'b1;
              write      <= 1'b0;
              byteenable <= 4'hF;
              writedata  <= '0;
            end
          end
        end
        XFER: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (read) begin
              if (win_d) d_rdata <= readdata;
              else       i_rdata <= readdata;
            end
          end else if (abort) begin
            // aborted access: strobes drop, read data registers keep their old value
            read  <= 1'b0;
            write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign i_done = (state == DONE) && !win_d;
  assign d_done = (state == DONE) && win_d;

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       err_flag;

  assign abort = (state == XFER) && waitrequest && (stall_cnt == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_flag  <= 1'b0;
    end else if (state == IDLE) begin
      stall_cnt <= '0;
      err_flag  <= 1'b0;
    end else if (state == XFER && waitrequest) begin
      stall_cnt <= stall_cnt + 8'd1;
      if (abort) err_flag <= 1'b1;
    end
  end

  assign err = (state == DONE) && err_flag;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

endmodule
